// File: rtl/search_tab_locator.sv
`default_nettype none
// ============================================================================
// Module      : search_tab_locator
// Description : Front-end of the 10G RAM search path. Splits a flat byte
//               index across the concatenated search tables into a table
//               number and an in-table byte offset, using a range check
//               followed by a P_TAB_W-step restoring division by P_TAB_BYTES.
// Ports       : clk, rst_n            - clock, async active-low reset
//               s_valid/s_ready       - request handshake
//               s_byte_idx, s_tab_cnt - flat index, number of active tables
//               m_valid/m_ready       - result handshake
//               m_tab, m_offset       - table number, offset inside the table
//               m_err                 - index out of range or no tables
// Revision    : 1.0 - initial release
// ============================================================================
module search_tab_locator #(
    parameter int P_TAB_BYTES = 1399,
    parameter int P_IDX_W     = 16,
    parameter int P_TAB_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [P_IDX_W-1:0] s_byte_idx,
    input  logic [P_TAB_W-1:0] s_tab_cnt,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [P_TAB_W-1:0] m_tab,
    output logic [P_IDX_W-1:0] m_offset,
    output logic               m_err
);

    // Arithmetic width wide enough for cnt*P_TAB_BYTES and P_TAB_BYTES<<k.
    localparam int               c_w       = P_IDX_W + P_TAB_W;
    localparam int               c_k_w     = (P_TAB_W > 1) ? $clog2(P_TAB_W) : 1;
    localparam logic [c_k_w-1:0] c_k_first = c_k_w'(P_TAB_W - 1);
    localparam logic [c_w-1:0]   c_div     = c_w'(P_TAB_BYTES);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_check = 2'd1;
    localparam logic [1:0] c_st_div   = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [P_IDX_W-1:0] r_rem;
    logic [P_TAB_W-1:0] r_cnt;
    logic [P_TAB_W-1:0] r_q;
    logic [c_k_w-1:0]   r_k;

    logic [c_w-1:0]     w_rem_ext;
    logic [c_w-1:0]     w_limit;
    logic [c_w-1:0]     w_d;
    logic [c_w-1:0]     w_diff;
    logic               w_chk_err;
    logic               w_ge;
    logic [P_IDX_W-1:0] w_rem_next;
    logic [P_TAB_W-1:0] w_q_next;
    logic               w_accept;

    assign w_accept  = s_valid && s_ready;
    assign w_rem_ext = {{P_TAB_W{1'b0}}, r_rem};
    assign w_limit   = {{P_IDX_W{1'b0}}, r_cnt} * c_div;
    assign w_chk_err = (r_cnt == '0) || (w_rem_ext >= w_limit);

    // One restoring-division step: trial-subtract the divisor shifted to
    // the current quotient bit position.
    assign w_d        = c_div << r_k;
    assign w_ge       = (w_rem_ext >= w_d);
    assign w_diff     = w_rem_ext - w_d;
    assign w_rem_next = w_ge ? w_diff[P_IDX_W-1:0] : r_rem;

    always_comb begin
        w_q_next      = r_q;
        w_q_next[r_k] = w_ge;
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle:  if (w_accept) w_state_next = c_st_check;
            c_st_check: w_state_next = w_chk_err ? c_st_done : c_st_div;
            c_st_div:   if (r_k == '0) w_state_next = c_st_done;
            c_st_done:  if (m_ready) w_state_next = c_st_idle;
            default:    w_state_next = c_st_idle;
        endcase
    end

    // ---------------- output logic ----------------
    // Gating with rst_n keeps the upstream stalled while reset is held.
    always_comb begin
        s_ready = (r_state == c_st_idle) && rst_n;
        m_valid = (r_state == c_st_done);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_cnt    <= '0;
            r_q      <= '0;
            r_k      <= '0;
            m_tab    <= '0;
            m_offset <= '0;
            m_err    <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_rem <= s_byte_idx;
                        r_cnt <= s_tab_cnt;
                        r_q   <= '0;
                    end
                end
                c_st_check: begin
                    if (w_chk_err) begin
                        m_err    <= 1'b1;
                        m_tab    <= '0;
                        m_offset <= r_rem;
                    end else begin
                        r_k <= c_k_first;
                    end
                end
                c_st_div: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_k   <= r_k - 1'b1;
                    if (r_k == '0) begin
                        m_tab    <= w_q_next;
                        m_offset <= w_rem_next;
                        m_err    <= 1'b0;
                    end
                end
                default: ;  // DONE: results held until the handshake
            endcase
        end
    end

endmodule
`default_nettype wire
